// File: rtl/count_pkg.sv
// ============================================================================
// count_pkg -- shared defaults and helpers for the count_up counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package count_pkg;

  localparam int COUNT_WIDTH_DEF = 4;
  localparam int COUNT_MOD_DEF   = 16;

  // True when a modulus is usable with a counter of the given width.
  function automatic bit modulus_fits(input int width, input int modulus);
    return (modulus >= 2) && (modulus <= (1 << width));
  endfunction

endpackage

`default_nettype wire

// File: rtl/dff_sync.sv
// ============================================================================
// dff_sync -- single-bit D flip-flop with synchronous active-high reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dff_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) q <= 1'b0;
    else       q <= d;
  end

endmodule

`default_nettype wire

// File: rtl/count_up.sv
// ============================================================================
// count_up -- modulo-N up counter with load, terminal count and wrap pulse.
// Optional build macro: COUNT_UP_SATURATE_EN (hold at MODULUS-1, no wrap).
// Revision: 1.0
// ============================================================================
`default_nettype none

module count_up
  import count_pkg::*;
#(
  parameter int WIDTH   = COUNT_WIDTH_DEF,
  parameter int MODULUS = COUNT_MOD_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  if (!modulus_fits(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("count_up: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  // MODULUS can be 2**WIDTH, so the load-range compare needs one extra bit.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);

  logic             at_max;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] q_inc;
  logic [WIDTH-1:0] q_term;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  assign at_max       = (q == MAX_Q);
  assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_Q : load_val;
  assign q_inc        = q + WIDTH'(1);

`ifdef COUNT_UP_SATURATE_EN
  assign q_term    = MAX_Q;
  assign wrap_next = 1'b0;
`else
  assign q_term    = '0;
  assign wrap_next = en && !load && at_max;
`endif

  always_comb begin
    q_next = q;
    if (load)      q_next = load_clamped;
    else if (en)   q_next = at_max ? q_term : q_inc;
  end

  assign tc = en && !load && at_max;

  for (genvar i = 0; i < WIDTH; i++) begin : g_q_bits
    dff_sync u_q_ff (
      .clk   (clk),
      .reset (reset),
      .d     (q_next[i]),
      .q     (q[i])
    );
  end

  dff_sync u_wrap_ff (
    .clk   (clk),
    .reset (reset),
    .d     (wrap_next),
    .q     (wrap)
  );

endmodule

`default_nettype wire

// File: tb/tb_count_up.sv
// ============================================================================
// tb_count_up -- directed vector bench for count_up (MODULUS=10 and default).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_count_up;

  logic       clk = 1'b0;
  logic       reset, en, load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc, wrap;

  logic       reset16, en16, load16;
  logic [3:0] load_val16;
  logic [3:0] q16;
  logic       tc16, wrap16;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  count_up #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .q(q), .tc(tc), .wrap(wrap)
  );

  count_up dut16 (
    .clk(clk), .reset(reset16), .en(en16), .load(load16), .load_val(load_val16),
    .q(q16), .tc(tc16), .wrap(wrap16)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       ld;
    logic [3:0] lv;
    logic       tc_pre;
    logic [3:0] q_post;
    logic       wrap_post;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic l, input logic [3:0] v);
    reset = r; en = e; load = l; load_val = v;
  endtask

  int  qm;
  bit  sat;

  initial begin
`ifdef COUNT_UP_SATURATE_EN
    sat = 1'b1;
`else
    sat = 1'b0;
`endif
    //            rst en ld lv  tc  q  wrap
    vecs[0]  = '{0, 1, 0, 0,  0, 1, 0};
    vecs[1]  = '{0, 1, 0, 0,  0, 2, 0};
    vecs[2]  = '{0, 1, 0, 0,  0, 3, 0};
    vecs[3]  = '{0, 1, 1, 7,  0, 7, 0};
    vecs[4]  = '{0, 1, 1, 12, 0, 9, 0};
    vecs[5]  = '{0, 0, 1, 3,  0, 3, 0};
    vecs[6]  = '{0, 1, 0, 0,  0, 4, 0};
    vecs[7]  = '{0, 0, 0, 0,  0, 4, 0};
    vecs[8]  = '{0, 0, 0, 0,  0, 4, 0};
    vecs[9]  = '{0, 0, 0, 0,  0, 4, 0};
    vecs[10] = '{0, 0, 0, 0,  0, 4, 0};
    vecs[11] = '{0, 0, 0, 0,  0, 4, 0};
    vecs[12] = '{0, 1, 0, 0,  0, 5, 0};
    vecs[13] = '{0, 1, 0, 0,  0, 6, 0};
    vecs[14] = '{1, 1, 1, 5,  0, 0, 0};
    vecs[15] = '{0, 0, 1, 9,  0, 9, 0};
    vecs[16] = '{0, 0, 0, 0,  0, 9, 0};
    vecs[17] = '{1, 1, 0, 0,  1, 0, 0};
    vecs[18] = '{0, 0, 1, 15, 0, 9, 0};
    vecs[19] = '{0, 1, 1, 9,  0, 9, 0};
    vecs[20] = '{0, 1, 1, 10, 0, 9, 0};
    vecs[21] = '{0, 1, 1, 8,  0, 8, 0};
    vecs[22] = '{0, 1, 0, 0,  0, 9, 0};

    drive(1, 1, 1, 4'd6);
    reset16 = 1; en16 = 0; load16 = 0; load_val16 = 0;
    step();
    step();

    // Reset state, with en/load still asserted so reset priority is exercised.
    chk("reset_q", int'(q), 0);
    chk("reset_wrap", int'(wrap), 0);
    drive(0, 1, 0, 0);
    #1;
    chk("reset_tc", int'(tc), 0);

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].lv);
      #1;
      chk($sformatf("vec%0d_tc", i), int'(tc), int'(vecs[i].tc_pre));
      step();
      chk($sformatf("vec%0d_q", i), int'(q), int'(vecs[i].q_post));
      chk($sformatf("vec%0d_wrap", i), int'(wrap), int'(vecs[i].wrap_post));
    end

    // Free-running count from reset across the terminal count.
    drive(1, 0, 0, 0);
    step();
    qm = 0;
    for (int i = 1; i <= 15; i++) begin
      drive(0, 1, 0, 0);
      #1;
      chk($sformatf("run%0d_tc", i), int'(tc), (qm == 9) ? 1 : 0);
      step();
      chk($sformatf("run%0d_wrap", i), int'(wrap), (!sat && qm == 9) ? 1 : 0);
      if (qm == 9) qm = sat ? 9 : 0;
      else         qm = qm + 1;
      chk($sformatf("run%0d_q", i), int'(q), qm);
    end

    // Wrap pulse must drop on the following load and on a hold.
    drive(0, 0, 1, 9);
    step();
    drive(0, 1, 0, 0);
    step();
    chk("wrap_edge_q", int'(q), sat ? 9 : 0);
    chk("wrap_edge_wrap", int'(wrap), sat ? 0 : 1);
    drive(0, 1, 1, 2);
    step();
    chk("wrap_after_load", int'(wrap), 0);
    chk("load_after_wrap_q", int'(q), 2);
    drive(0, 0, 0, 0);
    step();
    chk("wrap_after_hold", int'(wrap), 0);

    // Default-parameter instance: full 4-bit range, wrap from 15.
    reset16 = 0; load16 = 1; load_val16 = 4'd15;
    step();
    chk("m16_load_q", int'(q16), 15);
    load16 = 0; en16 = 1;
    #1;
    chk("m16_tc", int'(tc16), 1);
    step();
    chk("m16_q_next", int'(q16), sat ? 15 : 0);
    chk("m16_wrap", int'(wrap16), sat ? 0 : 1);
    en16 = 0;
    step();
    chk("m16_wrap_clear", int'(wrap16), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/count_up.md
COUNT_UP -- requirements
Module: count_up

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 SHALL have parameter MODULUS, default 16, giving the count sequence length (0..MODULUS-1).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: count enable.
REQ-006 SHALL have port load, input, 1 bit: synchronous parallel load request.
REQ-007 SHALL have port load_val, input, WIDTH bits: value to load.
REQ-008 SHALL have port q, output, WIDTH bits: registered count value.
REQ-009 SHALL have port tc, output, 1 bit: combinational terminal-count indication.
REQ-010 SHALL have port wrap, output, 1 bit: registered one-cycle wrap pulse.

Function
REQ-011 SHALL update state with priority reset > load > en > hold, evaluated each rising clk edge.
REQ-012 SHALL, when load=1 (reset=0), set q to load_val on the next edge (1-cycle latency), regardless of en.
REQ-013 SHALL clamp a load_val >= MODULUS to MODULUS-1.
REQ-014 SHALL, when en=1 and load=0, set next q to q+1 if q < MODULUS-1.
REQ-015 SHALL, when en=1, load=0 and q = MODULUS-1, set next q to 0 (wrap-around).
REQ-016 SHALL hold q unchanged when en=0 and load=0.
REQ-017 SHALL drive tc = en AND NOT load AND (q == MODULUS-1); tc is a function of current inputs and q only.
REQ-018 SHALL assert wrap for exactly the one cycle in which q has just wrapped from MODULUS-1 to 0, and deassert it otherwise, including after a load or hold.
REQ-019 SHALL never produce q >= MODULUS from any input sequence.
REQ-020 SHALL perform increment arithmetic in WIDTH bits, with no carry beyond bit WIDTH-1.
REQ-021 SHALL fail elaboration unless 2 <= MODULUS <= 2**WIDTH.

Reset
REQ-022 SHALL, on any edge with reset=1, set q=0 and wrap=0, overriding load and en, including mid-count.
REQ-023 SHALL hold tc=0 while q=0 after reset, given MODULUS >= 2.
REQ-024 SHALL have no asynchronous reset path; reset has no effect between clock edges.

Configuration
REQ-025 SHALL, with macro COUNT_UP_SATURATE_EN defined, hold q at MODULUS-1 when en=1 at terminal count instead of wrapping; wrap stays 0 permanently and tc still asserts per REQ-017.
REQ-026 SHALL, without COUNT_UP_SATURATE_EN, wrap per REQ-015 and REQ-018.

Structure
REQ-027 SHALL place COUNT_WIDTH_DEF (4) and COUNT_MOD_DEF (16) in shared package count_pkg; parameter defaults reference these constants.
REQ-028 SHALL build state from sub-module dff_sync (1-bit D flop, sync active-high reset, clk/reset/d/q), instantiated WIDTH times for q and once for wrap.
REQ-029 SHALL keep next-state logic (load clamp, increment, wrap/saturate select) combinational in count_up.

Verification (WIDTH=4, MODULUS=10 unless noted)
REQ-030 Reset, then en=1 for 12 cycles -> q = 0,1,...,9,0,1; tc=1 only while q=9; wrap=1 only in the cycle q first reads 0 after 9.
REQ-031 At q=3: load=1, load_val=7, en=1 -> next q=7. Then load_val=12 -> next q=9. wrap=0 throughout.
REQ-032 At q=4: en=0, load=0 for 5 cycles -> q stays 4, tc=0, wrap=0.
REQ-033 At q=6: reset=1 with load=1, load_val=5, en=1 -> next q=0, wrap=0. At q=9, tc=1: reset=1 -> q=0, wrap=0.
REQ-034 COUNT_UP_SATURATE_EN defined, en=1 for 15 cycles from reset -> q climbs to 9 and holds; tc=1 from q=9 on; wrap never 1.
REQ-035 Defaults (WIDTH=4, MODULUS=16), load 15 then en=1 -> q=0 next, wrap=1 one cycle; MODULUS=17 with WIDTH=4 -> elaboration error.
